pipeline_adder_result_buffer: RTL and testbench

//  Downstream companion of the 3-stage pipelined 64-bit adder (two internal register banks, latency 2).

---
 rtl/pipeline_adder_pkg.sv | 15 +
 rtl/result_fifo.sv | 72 +++++++
 rtl/pipeline_adder_result_buffer.sv | 107 ++++++++++
 tb/tb_pipeline_adder_result_buffer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_adder_pkg.sv
// Shared types and constants for the pipelined adder and its result buffer.
package pipeline_adder_pkg;

  localparam int unsigned ADD_WIDTH   = 64;
  localparam int unsigned ADD_LATENCY = 2;   // must match the adder's register banks
  localparam int unsigned ADD_TAG_W   = 4;

  // One completed add as it sits in the result FIFO
  typedef struct packed {
    logic [ADD_WIDTH-1:0] sum;
    logic                 cout;
    logic [ADD_TAG_W-1:0] tag;
  } add_result_t;

endpackage

// File: rtl/result_fifo.sv
// Result FIFO: DEPTH entries (power of 2), wrapping pointers, occupancy count.
// A pop against an empty FIFO is ignored; a push into a full FIFO without a
// matching pop cannot happen when fed through the credit logic upstream.
module result_fifo
  import pipeline_adder_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = add_result_t,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  entry_t           push_data_i,
  input  logic             pop_i,
  output entry_t           head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and count next-state; simultaneous push+pop leaves count unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, cleared on reset so the idle head reads as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Overflow would mean the credit accounting upstream is broken
  no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop_ok && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/pipeline_adder_result_buffer.sv
// Result buffer behind the pipelined adder: tracks issued adds in a valid/tag
// shadow pipe matching the adder latency, captures sum/cout into a FIFO and
// grants in_ready only when a FIFO slot is guaranteed for every add in flight.
// Optional: define ADDER_BUF_LEVEL_EN to expose level = count + inflight.
module pipeline_adder_result_buffer
  import pipeline_adder_pkg::*;
#(
  parameter int unsigned WIDTH   = ADD_WIDTH,
  parameter int unsigned LATENCY = ADD_LATENCY,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = ADD_TAG_W,
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag
`ifdef ADDER_BUF_LEVEL_EN
  ,
  output logic [LVL_W-1:0] level
`endif
);

  logic [LATENCY-1:0] sh_vld_q, sh_vld_d;
  logic [TAG_W-1:0]   sh_tag_q [LATENCY];
  logic [TAG_W-1:0]   sh_tag_d [LATENCY];
  logic [LVL_W-1:0]   inflight;
  logic [LVL_W-1:0]   occupancy;
  logic [LVL_W-1:0]   count;
  logic               issue;
  logic               push;
  logic               pop;
  add_result_t        push_data;
  add_result_t        head;

  assign issue = in_valid && in_ready;
  assign push  = sh_vld_q[LATENCY-1];
  assign pop   = out_valid && out_ready;

  // Shadow pipe shift: stage 0 takes this cycle's issue, others follow the adder
  always_comb begin
    sh_vld_d    = sh_vld_q;
    sh_tag_d    = sh_tag_q;
    sh_vld_d[0] = issue;
    sh_tag_d[0] = in_tag;
    for (int i = 1; i < int'(LATENCY); i++) begin
      sh_vld_d[i] = sh_vld_q[i-1];
      sh_tag_d[i] = sh_tag_q[i-1];
    end
  end

  // Shadow pipe registers; reset drops anything the adder still has in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_vld_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) sh_tag_q[i] <= '0;
    end else begin
      sh_vld_q <= sh_vld_d;
      sh_tag_q <= sh_tag_d;
    end
  end

  // Credit accounting from registered state only, so out_ready never reaches in_ready
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(LATENCY); i++) inflight = inflight + LVL_W'(sh_vld_q[i]);
    occupancy = count + inflight;
    in_ready  = (occupancy < LVL_W'(DEPTH));
  end

  // Pair the adder output with the tag that travelled alongside it
  always_comb begin
    push_data.sum  = add_sum;
    push_data.cout = add_cout;
    push_data.tag  = sh_tag_q[LATENCY-1];
  end

  result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign out_valid = (count != '0);
  assign out_sum   = head.sum;
  assign out_cout  = head.cout;
  assign out_tag   = head.tag;

`ifdef ADDER_BUF_LEVEL_EN
  assign level = occupancy;
`endif

endmodule

// File: tb/tb_pipeline_adder_result_buffer.sv
// Bench for pipeline_adder_result_buffer with a behavioural 2-bank adder in front.
// Expected results are queued at issue; a monitor pops and compares on each DUT pop.
module tb_pipeline_adder_result_buffer;
  import pipeline_adder_pkg::*;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] s;
    logic        co;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_tag = '0;
  logic [63:0] add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_sum;
  logic        out_cout;
  logic [3:0]  out_tag;
`ifdef ADDER_BUF_LEVEL_EN
  logic [2:0]  level;
`endif

  logic [63:0] op_a = '0;
  logic [63:0] op_b = '0;
  logic        op_cin = 1'b0;
  logic [64:0] adr_s1 = 65'h1_A5A5_5A5A_DEAD_BEEF;
  logic [64:0] adr_s2 = 65'h1_0BAD_F00D_1234_5678;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  bit          t5_done = 1'b0;
  add_result_t exp_q [$];
  int          pop_cyc [$];
  vec_t        vt [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural adder: two register banks, no reset, so stale sums linger
  always @(posedge clk) begin
    adr_s1 <= {1'b0, op_a} + {1'b0, op_b} + 65'(op_cin);
    adr_s2 <= adr_s1;
  end
  assign add_sum  = adr_s2[63:0];
  assign add_cout = adr_s2[64];

  pipeline_adder_result_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tag    (in_tag),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_tag   (out_tag)
`ifdef ADDER_BUF_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every DUT pop must match the oldest expected result
  initial begin
    forever begin
      add_result_t e;
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_result: got tag %0h sum %0h expected no result", out_tag, out_sum);
        end else begin
          e = exp_q.pop_front();
          check("result", 128'({out_sum, out_cout, out_tag}), 128'(e));
        end
      end
    end
  end

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic cin,
                       input logic [3:0] tag, input logic [63:0] esum, input logic ecout,
                       output bit took);
    @(negedge clk);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    in_tag   = tag;
    #1;
    took = in_ready && rst_n;
    if (took) exp_q.push_back('{sum: esum, cout: ecout, tag: tag});
  endtask

  task automatic issue_vec(input int idx, input logic [3:0] tag, output bit took);
    issue(vt[idx].a, vt[idx].b, vt[idx].cin, tag, vt[idx].s, vt[idx].co, took);
  endtask

  // Keep presenting one add until it is accepted
  task automatic issue_retry(input int idx);
    bit          took;
    logic [63:0] a, b;
    logic        cin;
    logic [64:0] s;
    int          tries;
    a = 64'(idx) * 64'h0F1E_2D3C_4B5A_6978;
    b = 64'hFFFF_0000_FFFF_0000 ^ 64'(idx << 8);
    cin = idx[0];
    s = {1'b0, a} + {1'b0, b} + 65'(cin);
    took = 1'b0;
    tries = 0;
    while (!took && tries < 50) begin
      issue(a, b, cin, 4'(idx), s[63:0], s[64], took);
`ifdef ADDER_BUF_LEVEL_EN
      check("t5_level_bound", 128'(level <= 3'd4), 128'(1));
`endif
      tries++;
    end
    if (!took) begin
      n_total++;
      $display("FAIL t5_issue_timeout: got no accept for add %0d expected accept within 50 cycles", idx);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
    end
    idle(1);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL %s_drain_timeout: got %0d results pending expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1);
  end

  initial begin
    bit took;
    int t0;
    int n_iss;

    vt[0] = '{a: 64'h1,                   b: 64'hFFFF_FFFF_FFFF_FFFF, cin: 1'b0, s: 64'h0,                   co: 1'b1};
    vt[1] = '{a: 64'h0,                   b: 64'h0,                   cin: 1'b1, s: 64'h1,                   co: 1'b0};
    vt[2] = '{a: 64'h8000_0000_0000_0000, b: 64'h8000_0000_0000_0000, cin: 1'b0, s: 64'h0,                   co: 1'b1};
    vt[3] = '{a: 64'h0000_0000_FFFF_FFFF, b: 64'h1,                   cin: 1'b0, s: 64'h0000_0001_0000_0000, co: 1'b0};
    vt[4] = '{a: 64'h1234_5678_9ABC_DEF0, b: 64'h1111_1111_1111_1111, cin: 1'b0, s: 64'h2345_6789_ABCD_F001, co: 1'b0};
    vt[5] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'hFFFF_FFFF_FFFF_FFFF, cin: 1'b1, s: 64'hFFFF_FFFF_FFFF_FFFF, co: 1'b1};
    vt[6] = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'h1,                   cin: 1'b0, s: 64'h8000_0000_0000_0000, co: 1'b0};
    vt[7] = '{a: 64'hDEAD_BEEF_0000_0000, b: 64'h0000_0000_CAFE_F00D, cin: 1'b1, s: 64'hDEAD_BEEF_CAFE_F00E, co: 1'b0};

    // Reset with in_valid high; stale adder outputs must not be pushed afterwards
    in_valid = 1'b1;
    op_a = 64'h5555_5555_5555_5555;
    op_b = 64'h3333_3333_3333_3333;
    repeat (3) @(negedge clk);
    #1;
    check("t1_in_ready", 128'(in_ready), 128'(1));
    check("t1_out_valid", 128'(out_valid), 128'(0));
    check("t1_out_sum", 128'(out_sum), 128'(0));
    check("t1_out_cout", 128'(out_cout), 128'(0));
    check("t1_out_tag", 128'(out_tag), 128'(0));
`ifdef ADDER_BUF_LEVEL_EN
    check("t1_level", 128'(level), 128'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      check("t1_no_stale_push", 128'(out_valid), 128'(0));
    end

    // Single add, out_valid exactly three cycles after issue
    out_ready = 1'b0;
    issue_vec(0, 4'd3, took);
    check("t2_accept", 128'(took), 128'(1));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (k < 3) begin
        check("t2_early_valid", 128'(out_valid), 128'(0));
      end else begin
        check("t2_out_valid", 128'(out_valid), 128'(1));
        check("t2_out_sum", 128'(out_sum), 128'(0));
        check("t2_out_cout", 128'(out_cout), 128'(1));
        check("t2_out_tag", 128'(out_tag), 128'(3));
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    wait_drain("t2");

    // Streaming: 8 back-to-back issues, results on consecutive cycles from t+3
    pop_cyc.delete();
    out_ready = 1'b1;
    t0 = 0;
    for (int i = 0; i < 8; i++) begin
      issue_vec(i, 4'(i), took);
      if (i == 0) t0 = cyc;
      check("t3_in_ready", 128'(took), 128'(1));
    end
    wait_drain("t3");
    check("t3_result_count", 128'(pop_cyc.size()), 128'(8));
    for (int i = 0; i < 8 && i < pop_cyc.size(); i++)
      check("t3_result_cycle", 128'(pop_cyc[i]), 128'(t0 + 3 + i));

    // Backpressure: exactly DEPTH issues accepted, then released
    out_ready = 1'b0;
    n_iss = 0;
    for (int i = 0; i < 8; i++) begin
      issue_vec(i, 4'(i + 8), took);
      if (took) n_iss++;
    end
    check("t4_accepted", 128'(n_iss), 128'(4));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t4_in_ready_low", 128'(in_ready), 128'(0));
    check("t4_out_valid", 128'(out_valid), 128'(1));
`ifdef ADDER_BUF_LEVEL_EN
    check("t4_level_full", 128'(level), 128'(4));
`endif
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("t4_in_ready_before_pop", 128'(in_ready), 128'(0));
    @(negedge clk);
    #1;
    check("t4_in_ready_after_pop", 128'(in_ready), 128'(1));
    wait_drain("t4");

    // Full boundary and pointer wrap: fill, then stream with patterned out_ready
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue_retry(i);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t5_full_in_ready", 128'(in_ready), 128'(0));
`ifdef ADDER_BUF_LEVEL_EN
    check("t5_level_full", 128'(level), 128'(4));
`endif
    t5_done = 1'b0;
    fork
      begin : t5_toggle
        int k;
        k = 0;
        while (!t5_done) begin
          @(negedge clk);
          out_ready = (k % 3) != 2;
          k++;
        end
      end
    join_none
    for (int i = 4; i < 20; i++) issue_retry(i);
    t5_done = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    out_ready = 1'b1;
    wait_drain("t5");

    // Reset mid-flight: one result in the FIFO, two adds in the shadow pipe
    out_ready = 1'b0;
    issue_vec(1, 4'd1, took);
    idle(2);
    issue_vec(2, 4'd2, took);
    issue_vec(3, 4'd4, took);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t6_pre_reset_valid", 128'(out_valid), 128'(1));
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_reset_out_valid", 128'(out_valid), 128'(0));
    check("t6_reset_in_ready", 128'(in_ready), 128'(1));
    check("t6_reset_out_sum", 128'(out_sum), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("t6_post_out_valid", 128'(out_valid), 128'(0));
      check("t6_post_in_ready", 128'(in_ready), 128'(1));
    end

    // Recovery after reset
    issue_vec(4, 4'd5, took);
    check("t6_recover_accept", 128'(took), 128'(1));
    wait_drain("t6");

    check("no_leftover", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
